cve2_vec_dispatch: RTL and testbench
====================================

Name: cve2_vec_dispatch

Overview:
- Sits between the ID stage and an external vector coprocessor.
- Accepts vector instructions from ID (opcodes LOAD_V 7'h07, STORE_V 7'h27, OP_V 7'h57) together with their scalar operands, buffers them in an in-order queue and issues them to the coprocessor over a valid/ready interface.
- Tracks outstanding issued instructions, checks that responses arrive in order, and forwards scalar write-backs to the register file.

Parameters:
- DEPTH, 4: queue entries; power of two, ≥2.
- TAG_W, 3: issue tag width.
- MAX_OUTST, 4: maximum issued-but-unanswered instructions; must be ≤ 2^TAG_W − 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- id_valid_i  in  1  ID offers an instruction
- id_ready_o  out  1  block accepts the offer
- id_instr_i  in  32  instruction word
- id_rs1_i  in  32  rs1 value
- id_rs2_i  in  32  rs2 value
- id_illegal_o  out  1  offered opcode is not a vector opcode
- flush_i  in  1  discard queued, not-yet-issued entries
- cop_valid_o  out  1  issue request
- cop_ready_i  in  1  coprocessor accepts
- cop_instr_o  out  32  issued instruction
- cop_rs1_o  out  32  issued rs1 value
- cop_rs2_o  out  32  issued rs2 value
- cop_tag_o  out  TAG_W  issue tag
- rsp_valid_i  in  1  coprocessor response
- rsp_tag_i  in  TAG_W  response tag
- rsp_we_i  in  1  response carries a scalar write-back
- rsp_rd_i  in  5  destination register
- rsp_data_i  in  32  write-back data
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  5  register-file write address
- rf_wdata_o  out  32  register-file write data
- rsp_err_o  out  1  out-of-order or spurious response
- busy_o  out  1  queue non-empty or responses outstanding

Behaviour:
- Reset: queue empty, issue_tag = 0, retire_tag = 0, outstanding = 0. rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0, rsp_err_o = 0. Combinational outputs follow from this state: cop_valid_o = 0, busy_o = 0, id_ready_o = 1.
- Reset asserted mid-operation discards all queued and outstanding state. Responses arriving later are treated as spurious.
- Vector opcode test: vec = (id_instr_i[6:0] ∈ {7'h07, 7'h27, 7'h57}).
- id_illegal_o (combinational) = id_valid_i & !vec. The offer is not enqueued.
- id_ready_o (combinational) = !full | !vec. An illegal offer is therefore always consumed in the same cycle.
- Enqueue on id_valid_i & id_ready_o & vec & !flush_i. If flush_i is high in that cycle, the offer is consumed and dropped.
- id_ready_o = !full regardless of a same-cycle dequeue; there is no full-passthrough.
- No empty bypass: an entry first appears on cop_* the cycle after enqueue. Minimum ID-to-issue latency is 1 cycle.
- cop_valid_o = !empty & (outstanding < MAX_OUTST) & !flush_i.
- cop_instr_o, cop_rs1_o and cop_rs2_o come from the queue head; cop_tag_o = issue_tag. All of these stay stable while cop_valid_o & !cop_ready_i.
- Issue handshake (cop_valid_o & cop_ready_i): pop the head, issue_tag += 1 (wraps mod 2^TAG_W), outstanding += 1.
- flush_i: empties the queue at the clock edge and suppresses cop_valid_o in that cycle, so no issue occurs. Outstanding instructions are unaffected and their responses still retire.
- Response (rsp_valid_i):
  - If outstanding > 0 and rsp_tag_i == retire_tag: retire_tag += 1, outstanding −= 1. If rsp_we_i and rsp_rd_i ≠ 0, next cycle rf_we_o = 1 with rf_waddr_o/rf_wdata_o = rsp_rd_i/rsp_data_i.
  - Otherwise: next cycle rsp_err_o = 1 for one cycle; no counter change and no write-back.
- rf_we_o and rsp_err_o are single-cycle registered pulses; 1-cycle latency from rsp_valid_i.
- rf_waddr_o/rf_wdata_o hold their last value when rf_we_o = 0.
- Issue and retire in the same cycle leave outstanding unchanged; both tags still advance.
- busy_o (combinational) = !empty | (outstanding ≠ 0). ID uses it to stall fences and scalar reads that hazard on a vector write-back.
- Queue pointers wrap modulo DEPTH. The full/empty distinction uses an extra pointer MSB.

Test Plan:
- Reset, then offer instr 32'h0000_0057 with rs1 = 32'hA, cop_ready_i = 1 → cop_valid_o rises 1 cycle later with cop_tag_o = 0 and cop_rs1_o = 32'hA; busy_o = 1 until the response.
- Offer instr 32'h0000_0033 → id_illegal_o = 1 and id_ready_o = 1 that cycle; nothing issued; busy_o stays 0.
- cop_ready_i = 0, offer 5 vector instrs with DEPTH = 4 → 4 accepted, id_ready_o = 0 on the 5th and held until cop_ready_i = 1; issue order and tags are 0, 1, 2, 3.
- Issue 4 with no responses → cop_valid_o = 0 despite a non-empty queue. Respond tag 0 with we = 1, rd = 5, data = 32'hDEAD → next cycle rf_we_o = 1, rf_waddr_o = 5, rf_wdata_o = 32'hDEAD, and a 5th issue follows with tag 4.
- Response with tag 2 while retire_tag = 1, then a response with outstanding = 0 → rsp_err_o pulses once each; counters are unchanged.
- 3 queued + 2 outstanding, assert flush_i for 1 cycle → no issue that cycle; queue empty next cycle; responses for tags of the 2 outstanding retire normally; busy_o falls after the last one. Asserting rst_i mid-stream clears all outputs asynchronously.

Source files
------------

// File: rtl/cve2_vec_dispatch.sv
// rtl/cve2_vec_dispatch.sv - in-order vector instruction queue, coprocessor issue and response retire
module cve2_vec_dispatch #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TAG_W     = 3,
    parameter int unsigned MAX_OUTST = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    output logic             id_ready_o,
    input  logic [31:0]      id_instr_i,
    input  logic [31:0]      id_rs1_i,
    input  logic [31:0]      id_rs2_i,
    output logic             id_illegal_o,
    input  logic             flush_i,
    output logic             cop_valid_o,
    input  logic             cop_ready_i,
    output logic [31:0]      cop_instr_o,
    output logic [31:0]      cop_rs1_o,
    output logic [31:0]      cop_rs2_o,
    output logic [TAG_W-1:0] cop_tag_o,
    input  logic             rsp_valid_i,
    input  logic [TAG_W-1:0] rsp_tag_i,
    input  logic             rsp_we_i,
    input  logic [4:0]       rsp_rd_i,
    input  logic [31:0]      rsp_data_i,
    output logic             rf_we_o,
    output logic [4:0]       rf_waddr_o,
    output logic [31:0]      rf_wdata_o,
    output logic             rsp_err_o,
    output logic             busy_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

    logic [95:0]      mem_q [DEPTH];
    logic [95:0]      mem_d [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [TAG_W-1:0] issue_tag_q, issue_tag_d;
    logic [TAG_W-1:0] retire_tag_q, retire_tag_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;
    logic             rsp_err_q, rsp_err_d;

    logic             vec, empty, full, enq, issue, retire;
    logic [95:0]      head;

    assign vec   = (id_instr_i[6:0] == 7'h07) || (id_instr_i[6:0] == 7'h27) ||
                   (id_instr_i[6:0] == 7'h57);
    assign empty = (wr_ptr_q == rd_ptr_q);
    // Same slot index but differing wrap bit means the writer lapped the reader.
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

    assign id_illegal_o = id_valid_i && !vec;
    assign id_ready_o   = !full || !vec;
    assign enq          = id_valid_i && id_ready_o && vec && !flush_i;

    assign cop_valid_o = !empty && (outst_q < CNT_W'(MAX_OUTST)) && !flush_i;
    assign cop_instr_o = head[95:64];
    assign cop_rs1_o   = head[63:32];
    assign cop_rs2_o   = head[31:0];
    assign cop_tag_o   = issue_tag_q;
    assign issue       = cop_valid_o && cop_ready_i;

    assign retire = rsp_valid_i && (outst_q != '0) && (rsp_tag_i == retire_tag_q);

    assign busy_o     = !empty || (outst_q != '0);
    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;
    assign rsp_err_o  = rsp_err_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        issue_tag_d  = issue_tag_q;
        retire_tag_d = retire_tag_q;
        outst_d      = outst_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        rsp_err_d    = 1'b0;

        if (enq) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = {id_instr_i, id_rs1_i, id_rs2_i};
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
        end else if (issue) begin
            rd_ptr_d    = rd_ptr_q + (PTR_W+1)'(1);
            issue_tag_d = issue_tag_q + TAG_W'(1);
        end

        if (retire) begin
            retire_tag_d = retire_tag_q + TAG_W'(1);
            if (rsp_we_i && (rsp_rd_i != 5'd0)) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = rsp_rd_i;
                rf_wdata_d = rsp_data_i;
            end
        end else if (rsp_valid_i) begin
            rsp_err_d = 1'b1;
        end

        case ({issue, retire})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            issue_tag_q  <= '0;
            retire_tag_q <= '0;
            outst_q      <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            issue_tag_q  <= issue_tag_d;
            retire_tag_q <= retire_tag_d;
            outst_q      <= outst_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_cve2_vec_dispatch.sv
// tb/tb_cve2_vec_dispatch.sv - randomized bench for cve2_vec_dispatch against a queue-based model
module tb_cve2_vec_dispatch;

    localparam int DEPTH     = 4;
    localparam int TAG_W     = 3;
    localparam int MAX_OUTST = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             id_valid_i;
    logic             id_ready_o;
    logic [31:0]      id_instr_i, id_rs1_i, id_rs2_i;
    logic             id_illegal_o;
    logic             flush_i;
    logic             cop_valid_o;
    logic             cop_ready_i;
    logic [31:0]      cop_instr_o, cop_rs1_o, cop_rs2_o;
    logic [TAG_W-1:0] cop_tag_o;
    logic             rsp_valid_i;
    logic [TAG_W-1:0] rsp_tag_i;
    logic             rsp_we_i;
    logic [4:0]       rsp_rd_i;
    logic [31:0]      rsp_data_i;
    logic             rf_we_o;
    logic [4:0]       rf_waddr_o;
    logic [31:0]      rf_wdata_o;
    logic             rsp_err_o;
    logic             busy_o;

    cve2_vec_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W), .MAX_OUTST(MAX_OUTST)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_instr_i(id_instr_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_illegal_o(id_illegal_o),
        .flush_i(flush_i),
        .cop_valid_o(cop_valid_o), .cop_ready_i(cop_ready_i), .cop_instr_o(cop_instr_o),
        .cop_rs1_o(cop_rs1_o), .cop_rs2_o(cop_rs2_o), .cop_tag_o(cop_tag_o),
        .rsp_valid_i(rsp_valid_i), .rsp_tag_i(rsp_tag_i), .rsp_we_i(rsp_we_i),
        .rsp_rd_i(rsp_rd_i), .rsp_data_i(rsp_data_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .rsp_err_o(rsp_err_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending instructions and the tags of issued, unanswered ones.
    logic [95:0] mq[$];
    int          oq[$];
    int          itag;
    logic        e_we, e_err;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        oq.delete();
        itag    = 0;
        e_we    = 1'b0;
        e_err   = 1'b0;
        e_waddr = '0;
        e_wdata = '0;
    endtask

    task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic fl, input logic rdy,
                        input logic rv, input logic [TAG_W-1:0] rtag, input logic rwe,
                        input logic [4:0] rrd, input logic [31:0] rdata);
        logic vec, ev, ok, issue, enq;
        logic [95:0] h;
        id_valid_i = v;  id_instr_i = instr; id_rs1_i = rs1; id_rs2_i = rs2;
        flush_i = fl;    cop_ready_i = rdy;
        rsp_valid_i = rv; rsp_tag_i = rtag; rsp_we_i = rwe; rsp_rd_i = rrd; rsp_data_i = rdata;
        #1;
        vec = (instr[6:0] == 7'h07) || (instr[6:0] == 7'h27) || (instr[6:0] == 7'h57);
        ev  = (mq.size() > 0) && (oq.size() < MAX_OUTST) && !fl;
        check("id_ready", 32'(id_ready_o), 32'((mq.size() < DEPTH) || !vec));
        check("id_illegal", 32'(id_illegal_o), 32'(v && !vec));
        check("cop_valid", 32'(cop_valid_o), 32'(ev));
        check("busy", 32'(busy_o), 32'((mq.size() > 0) || (oq.size() > 0)));
        if (ev) begin
            h = mq[0];
            check("cop_instr", cop_instr_o, h[95:64]);
            check("cop_rs1", cop_rs1_o, h[63:32]);
            check("cop_rs2", cop_rs2_o, h[31:0]);
            check("cop_tag", 32'(cop_tag_o), 32'(itag % 8));
        end
        ok    = rv && (oq.size() > 0) && (int'(rtag) == oq[0]);
        issue = ev && rdy;
        enq   = v && vec && !fl && (mq.size() < DEPTH);
        e_we  = ok && rwe && (rrd != 5'd0);
        e_err = rv && !ok;
        if (e_we) begin
            e_waddr = rrd;
            e_wdata = rdata;
        end
        if (ok) void'(oq.pop_front());
        if (issue) begin
            void'(mq.pop_front());
            oq.push_back(itag % 8);
            itag++;
        end
        if (fl) mq.delete();
        if (enq) mq.push_back({instr, rs1, rs2});
        @(posedge clk_i);
        #1;
        check("rf_we", 32'(rf_we_o), 32'(e_we));
        check("rsp_err", 32'(rsp_err_o), 32'(e_err));
        check("rf_waddr", 32'(rf_waddr_o), 32'(e_waddr));
        check("rf_wdata", rf_wdata_o, e_wdata);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, rdy, 1'b0, '0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic rand_cycle(input int p_valid, input int p_rdy, input int p_rsp, input int p_fl);
        logic [31:0] r, instr;
        logic [6:0]  op;
        logic [TAG_W-1:0] t;
        r = $urandom;
        case ($urandom_range(0, 4))
            0: op = 7'h07;
            1: op = 7'h27;
            2: op = 7'h57;
            3: op = 7'h33;
            default: op = r[6:0];
        endcase
        instr = {r[31:7], op};
        if ((oq.size() > 0) && ($urandom_range(0, 99) < 75)) t = TAG_W'(oq[0]);
        else t = TAG_W'($urandom_range(0, 7));
        step($urandom_range(0, 99) < p_valid, instr, $urandom, $urandom,
             $urandom_range(0, 99) < p_fl, $urandom_range(0, 99) < p_rdy,
             $urandom_range(0, 99) < p_rsp, t, 1'($urandom), 5'($urandom), $urandom);
    endtask

    initial begin
        rst_i = 1'b1;
        id_valid_i = 0; id_instr_i = 0; id_rs1_i = 0; id_rs2_i = 0; flush_i = 0;
        cop_ready_i = 0; rsp_valid_i = 0; rsp_tag_i = 0; rsp_we_i = 0; rsp_rd_i = 0;
        rsp_data_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_cop_valid", 32'(cop_valid_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_id_ready", 32'(id_ready_o), 32'h1);
        check("rst_rf_we", 32'(rf_we_o), 32'h0);
        rst_i = 1'b0;

        // single vector op, then an illegal scalar op
        step(1'b1, 32'h0000_0057, 32'hA, 32'h0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 5'd0, 32'h0);
        idle(1'b1);
        step(1'b1, 32'h0000_0033, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 5'd0, 32'h0);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 5'd3, 32'h1234);
        idle(1'b1);

        // fill to full with the coprocessor stalled, then drain with no responses
        for (int i = 0; i < 6; i++)
            step(1'b1, 32'h0000_0027 | (i << 12), i, ~i, 1'b0, 1'b0, 1'b0, '0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 6; i++) idle(1'b1);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 5'd5, 32'hDEAD);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 5'd5, 32'hBEEF);
        for (int i = 0; i < 4; i++)
            step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 3'(i + 2), 1'b1, 5'(i + 6), i);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0, 5'd0, 32'h0);

        // random phases: balanced, back-pressured, response-starved with flushes
        for (int i = 0; i < 300; i++) rand_cycle(70, 80, 60, 5);
        for (int i = 0; i < 300; i++) rand_cycle(80, 15, 50, 3);
        for (int i = 0; i < 300; i++) rand_cycle(90, 90, 10, 10);

        // asynchronous reset in the middle of traffic
        for (int i = 0; i < 5; i++)
            step(1'b1, 32'h0000_0007, i, i, 1'b0, 1'b1, 1'b0, '0, 1'b0, 5'd0, 32'h0);
        #2 rst_i = 1'b1;
        #1;
        check("arst_cop_valid", 32'(cop_valid_o), 32'h0);
        check("arst_busy", 32'(busy_o), 32'h0);
        check("arst_rf_waddr", 32'(rf_waddr_o), 32'h0);
        check("arst_rf_wdata", rf_wdata_o, 32'h0);
        model_reset();
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b1, 5'd1, 32'h1);
        for (int i = 0; i < 200; i++) rand_cycle(70, 70, 50, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
